// File: rtl/bitmap_pkg.sv
// Shared types and constants for the glyph bitmap decoder: state encoding, geometry, glyph table.
// Latency: n/a (package).  Backpressure: n/a.
// Macro BITMAP_DECODER_STRICT_EN selects full-nibble comparison; default ignores the spacer bit.
package bitmap_pkg;

    localparam int DATA_W    = 128;
    localparam int ROWS      = 8;
    localparam int ROW_W     = 16;
    localparam int ROW_IDX_W = 3;
    localparam int SLOTS     = 4;
    localparam int NIB_W     = 4;
    localparam int DIGITS    = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef BITMAP_DECODER_STRICT_EN
    localparam logic [NIB_W-1:0] CMP_MASK = 4'hF;
`else
    // Bit 0 is the spacer column between digits; noise there must not break a match.
    localparam logic [NIB_W-1:0] CMP_MASK = 4'hE;
`endif

    // Indexed as GLYPH_TBL[digit][row]; rows 0, 6 and 7 are blank for every digit.
    localparam logic [0:DIGITS-1][0:ROWS-1][NIB_W-1:0] GLYPH_TBL = {
        {4'h0, 4'hE, 4'hA, 4'hA, 4'hA, 4'hE, 4'h0, 4'h0},
        {4'h0, 4'h2, 4'h6, 4'hA, 4'h2, 4'h2, 4'h0, 4'h0},
        {4'h0, 4'hE, 4'h2, 4'hE, 4'h8, 4'hE, 4'h0, 4'h0},
        {4'h0, 4'hE, 4'h2, 4'h6, 4'h2, 4'hE, 4'h0, 4'h0},
        {4'h0, 4'hA, 4'hA, 4'hE, 4'h2, 4'h2, 4'h0, 4'h0},
        {4'h0, 4'hE, 4'h8, 4'hE, 4'h2, 4'hE, 4'h0, 4'h0},
        {4'h0, 4'hE, 4'h8, 4'hE, 4'hA, 4'hE, 4'h0, 4'h0},
        {4'h0, 4'hE, 4'h2, 4'h6, 4'h4, 4'h4, 4'h0, 4'h0},
        {4'h0, 4'hE, 4'hA, 4'hE, 4'hA, 4'hE, 4'h0, 4'h0},
        {4'h0, 4'hE, 4'hA, 4'hE, 4'h2, 4'hE, 4'h0, 4'h0}
    };

    // Returns {error, digit}: a unique survivor gives its digit, anything else gives 4'hF with error.
    function automatic logic [NIB_W:0] resolve_slot(input logic [DIGITS-1:0] mask);
        int               cnt;
        logic [NIB_W-1:0] dig;
        cnt = 0;
        dig = 4'hF;
        for (int d = 0; d < DIGITS; d++) begin
            if (mask[d]) begin
                cnt = cnt + 1;
                dig = NIB_W'(d);
            end
        end
        if (cnt == 1) begin
            return {1'b0, dig};
        end
        return {1'b1, 4'hF};
    endfunction

endpackage

// File: rtl/glyph_row_match.sv
// Compares one bitmap nibble against row `row` of every digit glyph, one match bit per digit.
// Latency: combinational.  Backpressure: none.
module glyph_row_match
    import bitmap_pkg::*;
(
    input  logic [NIB_W-1:0]     nibble,
    input  logic [ROW_IDX_W-1:0] row,
    output logic [DIGITS-1:0]    match
);

    always_comb begin
        match = '0;
        for (int d = 0; d < DIGITS; d++) begin
            match[d] = ((nibble ^ GLYPH_TBL[d][row]) & CMP_MASK) == '0;
        end
    end

endmodule

// File: rtl/bitmap_decoder.sv
// Decodes an 8x16 glyph bitmap into four BCD digits by eliminating candidates one row per cycle.
// Latency: start at edge 0 -> valid after edge 9.  Backpressure: start ignored while busy.
// Build option BITMAP_DECODER_STRICT_EN makes the spacer column significant in comparison.
module bitmap_decoder
    import bitmap_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_t,
    output logic              busy,
    output logic              valid,
    output logic [15:0]       currentTime,
    output logic [3:0]        error
);

    state_t                         state_q, state_d;
    logic [ROW_IDX_W-1:0]           row_q, row_d;
    logic [DATA_W-1:0]              data_q, data_d;
    logic [SLOTS-1:0][DIGITS-1:0]   mask_q, mask_d;
    logic                           valid_q, valid_d;
    logic [15:0]                    time_q, time_d;
    logic [3:0]                     err_q, err_d;

    logic [ROW_W-1:0]               row_word;
    logic [SLOTS-1:0][DIGITS-1:0]   match;

    assign row_word = data_q[(ROWS - 1 - int'(row_q)) * ROW_W +: ROW_W];

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        glyph_row_match u_match (
            .nibble (row_word[ROW_W-1-NIB_W*k -: NIB_W]),
            .row    (row_q),
            .match  (match[k])
        );
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        data_d  = data_q;
        mask_d  = mask_q;
        valid_d = 1'b0;
        time_d  = time_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data_t;
                    row_d   = '0;
                    mask_d  = '1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                for (int k = 0; k < SLOTS; k++) begin
                    mask_d[k] = mask_q[k] & match[k];
                end
                row_d = row_q + 1'b1;
                if (row_q == ROW_IDX_W'(ROWS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                for (int k = 0; k < SLOTS; k++) begin
                    {err_d[SLOTS-1-k], time_d[15-NIB_W*k -: NIB_W]} = resolve_slot(mask_q[k]);
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            data_q  <= '0;
            mask_q  <= '1;
            valid_q <= 1'b0;
            time_q  <= 16'hFFFF;
            err_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            time_q  <= time_d;
            err_q   <= err_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign valid       = valid_q;
    assign currentTime = time_q;
    assign error       = err_q;

endmodule

// File: tb/tb_bitmap_decoder.sv
// Scoreboard bench for bitmap_decoder: directed glyph cases plus randomized bitmaps vs a reference model.
module tb_bitmap_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data_t;
    logic         busy;
    logic         valid;
    logic [15:0]  currentTime;
    logic [3:0]   error;

    always #5 clk = ~clk;

    bitmap_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_t      (data_t),
        .busy        (busy),
        .valid       (valid),
        .currentTime (currentTime),
        .error       (error)
    );

    typedef struct packed {
        logic [15:0] t;
        logic [3:0]  e;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    // Glyph rows 1..5 per digit, written straight from the digit drawings.
    int glyph [10][5] = '{
        '{'hE, 'hA, 'hA, 'hA, 'hE},
        '{'h2, 'h6, 'hA, 'h2, 'h2},
        '{'hE, 'h2, 'hE, 'h8, 'hE},
        '{'hE, 'h2, 'h6, 'h2, 'hE},
        '{'hA, 'hA, 'hE, 'h2, 'h2},
        '{'hE, 'h8, 'hE, 'h2, 'hE},
        '{'hE, 'h8, 'hE, 'hA, 'hE},
        '{'hE, 'h2, 'h6, 'h4, 'h4},
        '{'hE, 'hA, 'hE, 'hA, 'hE},
        '{'hE, 'hA, 'hE, 'h2, 'hE}
    };

`ifdef BITMAP_DECODER_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    endtask

    function automatic logic [127:0] build(input logic [15:0] bcd);
        logic [127:0] b;
        int           dig;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            dig = int'(bcd[15-4*k -: 4]);
            for (int r = 1; r <= 5; r++) begin
                b[127-16*r-4*k -: 4] = 4'(glyph[dig][r-1]);
            end
        end
        return b;
    endfunction

    // A slot decodes to d when all eight rows equal d's drawing (spacer bit ignored unless strict).
    function automatic void model(input logic [127:0] b, output logic [15:0] t, output logic [3:0] e);
        logic [3:0] cmp;
        logic [3:0] nib;
        logic [3:0] gr;
        int         cnt;
        int         hit;
        bit         ok;
        cmp = STRICT ? 4'hF : 4'hE;
        t = '0;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            hit = 0;
            for (int d = 0; d < 10; d++) begin
                ok = 1'b1;
                for (int r = 0; r < 8; r++) begin
                    nib = b[127-16*r-4*k -: 4];
                    gr  = (r >= 1 && r <= 5) ? 4'(glyph[d][r-1]) : 4'h0;
                    if (((nib ^ gr) & cmp) != 4'h0) ok = 1'b0;
                end
                if (ok) begin
                    cnt++;
                    hit = d;
                end
            end
            if (cnt == 1) begin
                t[15-4*k -: 4] = 4'(hit);
                e[3-k] = 1'b0;
            end else begin
                t[15-4*k -: 4] = 4'hF;
                e[3-k] = 1'b1;
            end
        end
    endfunction

    // Monitor: every valid pops one expectation; between strobes outputs must hold.
    logic [15:0] last_t = 16'hFFFF;
    logic [3:0]  last_e = 4'b0000;
    logic        prev_v = 1'b0;
    exp_t        got;

    always @(negedge clk) begin
        if (rst) begin
            last_t = 16'hFFFF;
            last_e = 4'b0000;
            prev_v = 1'b0;
        end else begin
            if (valid) begin
                chk("valid_one_cycle", 32'(prev_v), 32'd0);
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    chk("currentTime", 32'(currentTime), 32'(got.t));
                    chk("error", 32'(error), 32'(got.e));
                    chk("latency_cycle", 32'(cyc), got.cyc);
                    last_t = got.t;
                    last_e = got.e;
                end
            end else begin
                chk("hold_time", 32'(currentTime), 32'(last_t));
                chk("hold_err", 32'(error), 32'(last_e));
            end
            prev_v = valid;
        end
    end

    task automatic issue(input logic [127:0] bm, input logic [15:0] et, input logic [3:0] ee, input bit push);
        start  = 1'b1;
        data_t = bm;
        if (push) sb.push_back('{t: et, e: ee, cyc: 32'(cyc + 10)});
        @(posedge clk); #1;
        start  = 1'b0;
        data_t = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_seen", 32'(valid), 32'd1);
    endtask

    initial begin
        logic [127:0] bm;
        logic [15:0]  bcd;
        logic [15:0]  mt;
        logic [3:0]   me;
        int           n;

        rst    = 1'b1;
        start  = 1'b0;
        data_t = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_time", 32'(currentTime), 32'hFFFF);
        chk("rst_err", 32'(error), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(build(16'h1234), 16'h1234, 4'h0, 1'b1);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", 32'(n), 32'd9);
        chk("valid_after_busy", 32'(valid), 32'd1);
        @(posedge clk); #1;

        issue(build(16'h0987), 16'h0987, 4'h0, 1'b1);
        wait_valid();
        issue(build(16'h5566), 16'h5566, 4'h0, 1'b1);
        wait_valid();
        @(posedge clk); #1;

        issue('0, 16'hFFFF, 4'b1111, 1'b1);
        wait_valid();
        @(posedge clk); #1;

        bm = build(16'h5555);
        bm[92] = 1'b1;
        if (STRICT) issue(bm, 16'hF555, 4'b1000, 1'b1);
        else        issue(bm, 16'h5555, 4'b0000, 1'b1);
        wait_valid();
        @(posedge clk); #1;

        issue(build(16'h4321), 16'h0, 4'h0, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_time", 32'(currentTime), 32'hFFFF);
        chk("abort_err", 32'(error), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
        end
        chk("abort_idle_busy", 32'(busy), 32'd0);

        issue(build(16'h2468), 16'h2468, 4'h0, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        start  = 1'b1;
        data_t = build(16'h1357);
        @(posedge clk); #1;
        start  = 1'b0;
        wait_valid();
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < 4; k++) bcd[15-4*k -: 4] = 4'($urandom_range(0, 9));
            bm = build(bcd);
            case ($urandom_range(0, 3))
                1: bm[$urandom_range(0, 127)] ^= 1'b1;
                2: bm = {$urandom, $urandom, $urandom, $urandom};
                3: begin
                    bm[$urandom_range(0, 127)] ^= 1'b1;
                    bm[$urandom_range(0, 127)] ^= 1'b1;
                end
                default: ;
            endcase
            model(bm, mt, me);
            issue(bm, mt, me, 1'b1);
            wait_valid();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/bitmap_decoder.md
BITMAP_DECODER -- requirements
Module: bitmap_decoder

Interface
REQ-001 SHALL expose clk, input, 1 bit: the single clock, rising-edge.
REQ-002 SHALL expose rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL expose start, input, 1 bit: request to decode data_t.
REQ-004 SHALL expose data_t, input, 128 bits: 8-row x 16-column glyph bitmap.
- Row r (0 = top) is data_t[127-16r -: 16].
- Digit slot k (0 = leftmost) within that row is nibble [127-16r-4k -: 4].
REQ-005 SHALL expose busy, output, 1 bit: decode in progress.
REQ-006 SHALL expose valid, output, 1 bit: one-cycle result strobe.
REQ-007 SHALL expose currentTime, output, 16 bits: recovered BCD digits.
- Slot 0 is [15:12], slot 3 is [3:0].
REQ-008 SHALL expose error, output, 4 bits: per-slot unrecognised-glyph flag.
- error[3] = slot 0, error[0] = slot 3.

Function
REQ-009 SHALL implement states IDLE, SCAN and DONE.
REQ-010 In IDLE with start=1 at an edge, SHALL latch data_t, clear row counter to 0, set every slot's 10-bit candidate mask to all-ones, and enter SCAN.
REQ-011 In SCAN, each edge SHALL clear candidate bits whose glyph row differs from the latched nibble for the current row, then increment the row counter; after row 7 SHALL enter DONE.
REQ-012 Glyph rows 0, 6 and 7 SHALL be 0000 for every digit.
REQ-013 Glyph rows 1-5, top to bottom:
- 0 = 1110,1010,1010,1010,1110
- 1 = 0010,0110,1010,0010,0010
- 2 = 1110,0010,1110,1000,1110
- 3 = 1110,0010,0110,0010,1110
- 4 = 1010,1010,1110,0010,0010
- 5 = 1110,1000,1110,0010,1110
- 6 = 1110,1000,1110,1010,1110
- 7 = 1110,0010,0110,0100,0100
- 8 = 1110,1010,1110,1010,1110
- 9 = 1110,1010,1110,0010,1110
REQ-014 In DONE, one edge SHALL register the decoded outputs, set valid=1 and return to IDLE.
- A slot with exactly one surviving candidate SHALL output that digit with its error bit 0.
- A slot with zero or multiple surviving candidates SHALL output 4'hF with its error bit 1.
REQ-015 Latency: start sampled at edge 0 SHALL produce valid=1 in the cycle following edge 9.
REQ-016 busy SHALL be 1 exactly while the state is SCAN or DONE.
REQ-017 start SHALL be ignored while busy=1.
- data_t changes after the latching edge SHALL NOT affect the result.
REQ-018 valid SHALL deassert at the next edge.
- currentTime and error SHALL hold until the next DONE.
REQ-019 start=1 in the valid cycle SHALL be accepted, since the state is IDLE.

Reset
REQ-020 rst=1 SHALL immediately force IDLE, row counter 0, busy=0, valid=0, currentTime=16'hFFFF and error=4'b0000, including mid-SCAN.
REQ-021 A decode aborted by reset SHALL never produce a valid strobe.

Configuration
REQ-022 With macro BITMAP_DECODER_STRICT_EN defined, comparison SHALL use all 4 bits of every nibble.
REQ-023 Without BITMAP_DECODER_STRICT_EN, bit 0 of each nibble (the spacer column) SHALL be ignored in comparison.

Structure
REQ-024 Package bitmap_pkg SHALL hold:
- the 10x8x4-bit glyph table
- row/slot width constants
- the state enumeration
REQ-025 Sub-module glyph_row_match SHALL map (nibble, row index) to a 10-bit match vector.
- It SHALL be instantiated four times, once per slot.

Verification
REQ-026 Bitmap of "1234", pulse start -> busy high for 9 cycles, then valid=1 one cycle, currentTime=16'h1234, error=0.
REQ-027 Bitmap of "0987" -> currentTime=16'h0987, error=0; repeat with "5566" and start held high in the valid cycle -> second result 16'h5566 exactly 10 cycles later.
REQ-028 All-zero bitmap -> currentTime=16'hFFFF, error=4'b1111.
REQ-029 Bitmap "5555" with data_t[92] set -> with STRICT_EN: error=4'b1000, currentTime=16'hF555; without STRICT_EN: error=0, currentTime=16'h5555.
REQ-030 Reset asserted during SCAN row 4 -> busy=0 immediately, currentTime=16'hFFFF, no valid pulse.
REQ-031 start re-pulsed while busy with a different bitmap -> ignored; the first bitmap's result is reported.
